// File: rtl/rv_csr_out_fifo.sv
// Output FIFO for the barrel-threaded core's CSR data-out bus: buffers {hart, data}
// words, drains them first-word-fall-through over valid/ready and counts drops taken while full.
module rv_csr_out_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int HART_WIDTH = 3,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [HART_WIDTH-1:0] wr_hart,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HART_WIDTH-1:0] out_hart,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            drop_cnt,
  input  logic                  drop_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][HART_WIDTH-1:0] hart_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, drop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO that is popping this cycle frees a slot in time for the write.
  assign push      = wr_en & (~full | pop);
  assign drop      = wr_en & full & ~pop;

  assign out_hart = hart_q[rd_ptr];
  assign out_data = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      hart_q   <= '0;
      data_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        hart_q[wr_ptr] <= wr_hart;
        data_q[wr_ptr] <= wr_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A clear coinciding with a drop still records that drop.
      if (drop_clr)                    drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rv_csr_out_fifo.sv
// Directed bench for rv_csr_out_fifo: ordering, fill/drop, full push+pop, drop counter, reset.
module tb_rv_csr_out_fifo;
  logic        clk = 1'b0;
  logic        rst, wr_en, out_ready, drop_clr;
  logic [2:0]  wr_hart, out_hart;
  logic [31:0] wr_data, out_data;
  logic        full, out_valid;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  int checks = 0;
  int errors = 0;

  rv_csr_out_fifo #(.DATA_WIDTH(32), .HART_WIDTH(3), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hart(wr_hart), .wr_data(wr_data),
    .full(full), .count(count), .out_valid(out_valid), .out_ready(out_ready),
    .out_hart(out_hart), .out_data(out_data), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0; drop_clr = 1'b0; wr_hart = '0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (out_data !== 32'd0 || out_hart !== 3'd0) begin errors++; $display("FAIL reset_head got %0h/%0h want 0/0", out_hart, out_data); end
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_hart = 3'd3; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    checks++; if (out_valid !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL single_valid got v=%b c=%0d want v=1 c=1", out_valid, count); end
    checks++; if (out_hart !== 3'd3 || out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_head got %0h/%0h want 3/deadbeef", out_hart, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL single_pop got v=%b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  task automatic test_order();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_hart = 3'(i % 8); wr_data = 32'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_hart !== 3'(i % 8) || count !== 4'd1) begin
        errors++; $display("FAIL order_%0d got v=%b h=%0d d=%0d c=%0d want v=1 h=%0d d=%0d c=1", i, out_valid, out_hart, out_data, count, i % 8, i);
      end
    end
    wr_en = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got c=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_fill_drop();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_hart = 3'(i); wr_data = 32'(100 + i);
      tick();
      if (i == 7) begin
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL fill_full got f=%b c=%0d want f=1 c=8", full, count); end
      end
    end
    wr_en = 1'b0;
    checks++; if (drop_cnt !== 8'd2 || count !== 4'd8) begin errors++; $display("FAIL fill_drop got d=%0d c=%0d want d=2 c=8", drop_cnt, count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(100 + i)) begin errors++; $display("FAIL fill_drain_%0d got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, 100 + i); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL fill_end got v=%b c=%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_hart = 3'd1; wr_data = 32'(200 + i);
      tick();
    end
    wr_data = 32'h55; out_ready = 1'b1;
    tick();
    wr_en = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL pp_count got c=%0d f=%b want c=8 f=1", count, full); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL pp_drop got %0d want 2", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      exp = (i == 7) ? 32'h55 : 32'(201 + i);
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL pp_drain_%0d got v=%b d=%0h want v=1 d=%0h", i, out_valid, out_data, exp); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_end got v=%b want 0", out_valid); end
  endtask

  task automatic test_drop_sat();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_hart = 3'd2; wr_data = 32'(300 + i);
      tick();
    end
    for (int i = 0; i < 300; i++) tick();
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", drop_cnt); end
    drop_clr = 1'b1;
    tick();
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL sat_clr_drop got %0d want 1", drop_cnt); end
    wr_en = 1'b0;
    tick();
    drop_clr = 1'b0;
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", drop_cnt); end
    checks++; if (count !== 4'd8 || out_data !== 32'd300) begin errors++; $display("FAIL sat_keep got c=%0d d=%0d want c=8 d=300", count, out_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    checks++; if (count !== 4'd5 || out_data !== 32'd303) begin errors++; $display("FAIL mid_pre got c=%0d d=%0d want c=5 d=303", count, out_data); end
    rst = 1'b1; wr_en = 1'b1; out_ready = 1'b1; wr_data = 32'hABCD;
    tick();
    rst = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got c=%0d v=%b want 0/0", count, out_valid); end
    checks++; if (drop_cnt !== 8'd0 || out_data !== 32'd0) begin errors++; $display("FAIL mid_rst_state got d=%0d data=%0h want 0/0", drop_cnt, out_data); end
    wr_en = 1'b1; wr_hart = 3'd5; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_hart !== 3'd5 || out_data !== 32'h1234 || count !== 4'd1) begin
      errors++; $display("FAIL mid_next got v=%b h=%0d d=%0h c=%0d want 1/5/1234/1", out_valid, out_hart, out_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_fill_drop();
    test_full_push_pop();
    test_drop_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
